// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: opcodes, FSM states, bus select indices, ALU codes.
// Optional AND instruction enabled by defining PROC_CTRL_AND_EN.
package proc_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;

   localparam int SEL_DIN = 0;
   localparam int SEL_R0  = 1;
   localparam int SEL_G   = 9;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;

   // Ops that take the three-step A <- Rx, G <- A op Ry, Rx <- G path.
   function automatic logic is_alu_op(input logic [2:0] op);
`ifdef PROC_CTRL_AND_EN
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`else
      return (op == OP_ADD) || (op == OP_SUB);
`endif
   endfunction

   function automatic logic [1:0] alu_code(input logic [2:0] op);
      logic [1:0] code;
      code = ALU_ADD;
      if (op == OP_SUB) begin
         code = ALU_SUB;
      end
`ifdef PROC_CTRL_AND_EN
      if (op == OP_AND) begin
         code = ALU_AND;
      end
`endif
      return code;
   endfunction

endpackage

// File: rtl/proc_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module proc_dec3to8 (
   input  logic [2:0] idx,
   input  logic       en,
   output logic [7:0] onehot
);

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign onehot[gi] = en && (idx == 3'(gi));
      end
   endgenerate

endmodule

// File: rtl/proc_ctrl.sv
// Control FSM for the simple processor datapath: decodes a latched 9-bit instruction over up to four timesteps.
// Define PROC_CTRL_AND_EN to make op 100 a three-step AND instead of a NOP.
module proc_ctrl
   import proc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [8:0] instr,
   output logic [9:0] sel,
   output logic [7:0] r_in,
   output logic       a_in,
   output logic       g_in,
   output logic [1:0] alu_op,
   output logic       done,
   output logic       busy
);

   state_t     state_reg, state_next;
   logic [8:0] ir_reg;

   logic [2:0] op, rx, ry;
   logic       din_sel, g_sel, reg_sel_en, r_en, a_en, g_en, done_dec;
   logic [2:0] reg_sel_idx;
   logic [7:0] reg_sel_oh;

   assign op = ir_reg[8:6];
   assign rx = ir_reg[5:3];
   assign ry = ir_reg[2:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         ir_reg    <= 9'h000;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_IDLE && run) begin
            ir_reg <= instr;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      din_sel     = 1'b0;
      g_sel       = 1'b0;
      reg_sel_en  = 1'b0;
      reg_sel_idx = ry;
      r_en        = 1'b0;
      a_en        = 1'b0;
      g_en        = 1'b0;
      done_dec    = 1'b0;
      alu_op      = ALU_ADD;
      case (state_reg)
         S_IDLE: begin
            din_sel = 1'b1;
            if (run) begin
               state_next = S_T1;
            end
         end
         S_T1: begin
            if (op == OP_MV) begin
               reg_sel_en = 1'b1;
               r_en       = 1'b1;
               done_dec   = 1'b1;
               state_next = S_IDLE;
            end else if (op == OP_MVI) begin
               din_sel    = 1'b1;
               r_en       = 1'b1;
               done_dec   = 1'b1;
               state_next = S_IDLE;
            end else if (is_alu_op(op)) begin
               reg_sel_en  = 1'b1;
               reg_sel_idx = rx;
               a_en        = 1'b1;
               state_next  = S_T2;
            end else begin
               // NOP keeps DIN on the bus so sel stays one-hot.
               din_sel    = 1'b1;
               done_dec   = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_T2: begin
            reg_sel_en = 1'b1;
            g_en       = 1'b1;
            alu_op     = alu_code(op);
            state_next = S_T3;
         end
         S_T3: begin
            g_sel      = 1'b1;
            r_en       = 1'b1;
            done_dec   = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            din_sel    = 1'b1;
            state_next = S_IDLE;
         end
      endcase
   end

   // Write strobes are suppressed while reset is high so an aborted instruction never commits.
   proc_dec3to8 u_dec_rin (
      .idx    (rx),
      .en     (r_en & ~reset),
      .onehot (r_in)
   );

   proc_dec3to8 u_dec_sel (
      .idx    (reg_sel_idx),
      .en     (reg_sel_en),
      .onehot (reg_sel_oh)
   );

   assign sel[SEL_DIN]         = din_sel;
   assign sel[SEL_R0 +: 8]     = reg_sel_oh;
   assign sel[SEL_G]           = g_sel;
   assign a_in                 = a_en & ~reset;
   assign g_in                 = g_en & ~reset;
   assign done                 = done_dec & ~reset;
   assign busy                 = (state_reg != S_IDLE);

endmodule

// File: tb/tb_proc_ctrl.sv
// Scoreboard bench for proc_ctrl: a step-table model queues expected per-cycle outputs; a negedge monitor compares.
module tb_proc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [8:0] instr;
   logic [9:0] sel;
   logic [7:0] r_in;
   logic       a_in, g_in, done, busy;
   logic [1:0] alu_op;

   int vectors = 0;
   int miscompares = 0;
   int rem = 0;          // model: busy cycles remaining, counting the current one
   bit mon_en = 1'b0;
   logic [22:0] exp_q[$];

   localparam logic [22:0] IDLE_VEC = {10'b0000000001, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0};

   proc_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .instr  (instr),
      .sel    (sel),
      .r_in   (r_in),
      .a_in   (a_in),
      .g_in   (g_in),
      .alu_op (alu_op),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [22:0] mk(input int sel_bit, input logic [7:0] rin, input logic a,
                                      input logic g, input logic [1:0] alu, input logic d);
      logic [9:0] s;
      s = 10'd1 << sel_bit;
      return {s, rin, a, g, alu, d};
   endfunction

   // Expected output table per instruction, written from the instruction semantics.
   function automatic int push_steps(input logic [8:0] ins);
      int op, rx, ry;
      logic [7:0] rxh;
      bit alu3;
      logic [1:0] code;
      op  = int'(ins[8:6]);
      rx  = int'(ins[5:3]);
      ry  = int'(ins[2:0]);
      rxh = 8'd1 << rx;
      alu3 = (op == 2) || (op == 3);
      code = (op == 3) ? 2'b01 : 2'b00;
`ifdef PROC_CTRL_AND_EN
      if (op == 4) begin
         alu3 = 1'b1;
         code = 2'b10;
      end
`endif
      if (op == 0) begin
         exp_q.push_back(mk(1 + ry, rxh, 0, 0, 2'b00, 1));
         return 1;
      end else if (op == 1) begin
         exp_q.push_back(mk(0, rxh, 0, 0, 2'b00, 1));
         return 1;
      end else if (alu3) begin
         exp_q.push_back(mk(1 + rx, 8'h00, 1, 0, 2'b00, 0));
         exp_q.push_back(mk(1 + ry, 8'h00, 0, 1, code, 0));
         exp_q.push_back(mk(9, rxh, 0, 0, 2'b00, 1));
         return 3;
      end
      exp_q.push_back(mk(0, 8'h00, 0, 0, 2'b00, 1));
      return 1;
   endfunction

   // Drive one cycle's inputs, advance the model, and step to just after the next edge.
   task automatic cycle(input logic r, input logic [8:0] ins);
      int rem_next;
      run   = r;
      instr = ins;
      if (rem == 0) begin
         rem_next = r ? push_steps(ins) : 0;
      end else begin
         rem_next = rem - 1;
      end
      @(posedge clk);
      #1;
      rem = rem_next;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", 32'(busy), 32'(rem > 0));
         if (busy) begin
            if (exp_q.size() == 0) begin
               chk("queue_underrun", 32'd1, 32'd0);
            end else begin
               chk("step_outputs", 32'({sel, r_in, a_in, g_in, alu_op, done}), 32'(exp_q.pop_front()));
            end
         end else begin
            chk("idle_outputs", 32'({sel, r_in, a_in, g_in, alu_op, done}), 32'(IDLE_VEC));
         end
      end
   end

   initial begin
      logic [8:0] dir_tab[6];
      dir_tab = '{9'b001_011_000, 9'b000_101_010, 9'b010_001_110,
                  9'b011_000_000, 9'b000_111_000, 9'b100_010_100};
      reset = 1'b1;
      run   = 1'b0;
      instr = 9'h000;
      @(posedge clk);
      #1;
      run = 1'b1;
      @(negedge clk);
      chk("reset_strobes", 32'({r_in, a_in, g_in, done}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run   = 1'b0;
      mon_en = 1'b1;
      cycle(1'b0, 9'h000);

      // Directed sequence, run held high so each follows the previous done back-to-back.
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, dir_tab[i]);
         while (rem > 0) begin
            cycle(1'b1, 9'($urandom_range(0, 511)));
         end
      end
      cycle(1'b0, 9'h000);

      // Abort an add in T2.
      cycle(1'b1, 9'b010_001_110);
      cycle(1'b0, 9'h000);
      mon_en = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      chk("abort_strobes", 32'({r_in, a_in, g_in, done}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      rem = 0;
      @(negedge clk);
      chk("abort_idle", 32'({busy, sel, r_in, a_in, g_in, alu_op, done}), 32'({1'b0, IDLE_VEC}));
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
      end
      while (rem > 0) begin
         cycle(1'b0, 9'h000);
      end
      cycle(1'b0, 9'h000);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
